// File: rtl/global_sram_streamer.sv
// global_sram_streamer: reads activation and weight words from the global SRAMs
// and forwards each word with its in-pass index to the row-memory distributors.
// K==3 runs one pass; every other K runs three passes over consecutive SRAM regions.
// Optional feature: define STREAM_STALL_EN to add a stall input backed by a
// 1-deep skid register per stream.
module global_sram_streamer #(
  parameter int unsigned ACT_PER_CORE     = 11,
  parameter int unsigned WEIGHT_PER_CORE  = 9,
  parameter int unsigned INPUT_BW         = 8,
  parameter int unsigned ACT_SRAM_ADDR    = 13,
  parameter int unsigned WEIGHT_SRAM_ADDR = 11
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
`ifdef STREAM_STALL_EN
  input  logic                              stall,
`endif
  output logic                              done,
  input  logic [5:0]                        OC,
  input  logic [5:0]                        IMG_H,
  input  logic [5:0]                        IMG_W,
  input  logic [2:0]                        K,
  output logic                              act_sram_en,
  output logic [ACT_SRAM_ADDR-1:0]          act_sram_addr,
  input  logic signed [INPUT_BW-1:0]        act_sram_rdata,
  output logic                              weight_sram_en,
  output logic [WEIGHT_SRAM_ADDR-1:0]       weight_sram_addr,
  input  logic signed [INPUT_BW-1:0]        weight_sram_rdata,
  output logic signed [INPUT_BW-1:0]        act_row_mem_data,
  output logic [ACT_PER_CORE-1:0]           act_row_mem_addr,
  output logic signed [INPUT_BW-1:0]        weight_row_mem_data,
  output logic [WEIGHT_PER_CORE-1:0]        weight_row_mem_addr
);

  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {IDLE, READ, NEXT_PASS, DONE} state_t;

  state_t                          state;
  logic [ACT_PER_CORE-1:0]         act_total, act_cnt, act_idx1, act_idx2, act_sk_idx;
  logic [WEIGHT_PER_CORE-1:0]      wgt_total, wgt_cnt, wgt_idx1, wgt_idx2, wgt_sk_idx;
  logic [ACT_SRAM_ADDR-1:0]        act_base;
  logic [WEIGHT_SRAM_ADDR-1:0]     wgt_base;
  logic [1:0]                      npass, pass_cnt;
  logic                            act_v2, wgt_v2, act_sk_v, wgt_sk_v;
  logic signed [INPUT_BW-1:0]      act_sk_d, wgt_sk_d;

  logic [PROD_W-1:0]               act_h_c, act_w_c;
  logic [ACT_PER_CORE-1:0]         act_total_c;
  logic [WEIGHT_PER_CORE-1:0]      wgt_total_c;
  logic                            stall_c, act_fin_c, wgt_fin_c;
  logic                            act_issue_c, wgt_issue_c, last_pass_c;

`ifdef STREAM_STALL_EN
  assign stall_c = stall && (state == READ);
`else
  assign stall_c = 1'b0;
`endif

  // Transfer sizes from the configuration inputs, and per-stream issue/finish status
  always_comb begin
    act_h_c     = PROD_W'(IMG_H) + PROD_W'(K) - PROD_W'(1);
    act_w_c     = PROD_W'(IMG_W) + PROD_W'(K) - PROD_W'(1);
    act_total_c = ACT_PER_CORE'(act_h_c * act_w_c);
    wgt_total_c = WEIGHT_PER_CORE'(PROD_W'(K) * PROD_W'(K) * PROD_W'(OC));
    act_fin_c   = (act_cnt == act_total) && !act_sram_en && !act_v2 && !act_sk_v;
    wgt_fin_c   = (wgt_cnt == wgt_total) && !weight_sram_en && !wgt_v2 && !wgt_sk_v;
    act_issue_c = (state == READ) && !stall_c && (act_cnt < act_total);
    wgt_issue_c = (state == READ) && !stall_c && (wgt_cnt < wgt_total);
    last_pass_c = (pass_cnt == npass - 2'd1);
  end

  // Control FSM, read issue, data alignment and skid handling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state               <= IDLE;
      done                <= 1'b0;
      act_total           <= '0;
      wgt_total           <= '0;
      npass               <= '0;
      pass_cnt            <= '0;
      act_base            <= '0;
      wgt_base            <= '0;
      act_cnt             <= '0;
      wgt_cnt             <= '0;
      act_idx1            <= '0;
      wgt_idx1            <= '0;
      act_idx2            <= '0;
      wgt_idx2            <= '0;
      act_v2              <= 1'b0;
      wgt_v2              <= 1'b0;
      act_sk_v            <= 1'b0;
      wgt_sk_v            <= 1'b0;
      act_sk_idx          <= '0;
      wgt_sk_idx          <= '0;
      act_sk_d            <= '0;
      wgt_sk_d            <= '0;
      act_sram_en         <= 1'b0;
      act_sram_addr       <= '0;
      weight_sram_en      <= 1'b0;
      weight_sram_addr    <= '0;
      act_row_mem_data    <= '0;
      act_row_mem_addr    <= '0;
      weight_row_mem_data <= '0;
      weight_row_mem_addr <= '0;
    end else begin
      done             <= 1'b0;
      act_sram_en      <= 1'b0;
      act_sram_addr    <= '0;
      weight_sram_en   <= 1'b0;
      weight_sram_addr <= '0;
      act_v2           <= 1'b0;
      wgt_v2           <= 1'b0;
      case (state)
        IDLE: begin
          act_row_mem_data    <= '0;
          act_row_mem_addr    <= '0;
          weight_row_mem_data <= '0;
          weight_row_mem_addr <= '0;
          act_sk_v            <= 1'b0;
          wgt_sk_v            <= 1'b0;
          if (start) begin
            act_total <= act_total_c;
            wgt_total <= wgt_total_c;
            npass     <= (K == 3'd3) ? 2'd1 : 2'd3;
            pass_cnt  <= '0;
            act_base  <= '0;
            wgt_base  <= '0;
            act_cnt   <= '0;
            wgt_cnt   <= '0;
            state     <= READ;
          end
        end

        READ: begin
          // Activation read issue; a read already on the bus when a stall
          // arrives is dropped and its index re-issued after release.
          if (act_issue_c) begin
            act_sram_en   <= 1'b1;
            act_sram_addr <= act_base + ACT_SRAM_ADDR'(act_cnt);
            act_idx1      <= act_cnt;
            act_cnt       <= act_cnt + ACT_PER_CORE'(1);
          end else if (stall_c && act_sram_en) begin
            act_cnt <= act_idx1;
          end
          act_v2   <= act_sram_en && !stall_c;
          act_idx2 <= act_idx1;

          // Activation output: finished hold, skid capture, skid drain, or direct
          if (act_fin_c) begin
            act_row_mem_addr <= act_total;
            act_row_mem_data <= '0;
          end else if (stall_c) begin
            if (act_v2) begin
              act_sk_v   <= 1'b1;
              act_sk_idx <= act_idx2;
              act_sk_d   <= act_sram_rdata;
            end
          end else if (act_sk_v) begin
            act_row_mem_addr <= act_sk_idx;
            act_row_mem_data <= act_sk_d;
            act_sk_v         <= act_v2;
            act_sk_idx       <= act_idx2;
            act_sk_d         <= act_sram_rdata;
          end else if (act_v2) begin
            act_row_mem_addr <= act_idx2;
            act_row_mem_data <= act_sram_rdata;
          end

          // Weight read issue
          if (wgt_issue_c) begin
            weight_sram_en   <= 1'b1;
            weight_sram_addr <= wgt_base + WEIGHT_SRAM_ADDR'(wgt_cnt);
            wgt_idx1         <= wgt_cnt;
            wgt_cnt          <= wgt_cnt + WEIGHT_PER_CORE'(1);
          end else if (stall_c && weight_sram_en) begin
            wgt_cnt <= wgt_idx1;
          end
          wgt_v2   <= weight_sram_en && !stall_c;
          wgt_idx2 <= wgt_idx1;

          // Weight output
          if (wgt_fin_c) begin
            weight_row_mem_addr <= wgt_total;
            weight_row_mem_data <= '0;
          end else if (stall_c) begin
            if (wgt_v2) begin
              wgt_sk_v   <= 1'b1;
              wgt_sk_idx <= wgt_idx2;
              wgt_sk_d   <= weight_sram_rdata;
            end
          end else if (wgt_sk_v) begin
            weight_row_mem_addr <= wgt_sk_idx;
            weight_row_mem_data <= wgt_sk_d;
            wgt_sk_v            <= wgt_v2;
            wgt_sk_idx          <= wgt_idx2;
            wgt_sk_d            <= weight_sram_rdata;
          end else if (wgt_v2) begin
            weight_row_mem_addr <= wgt_idx2;
            weight_row_mem_data <= weight_sram_rdata;
          end

          if (act_fin_c && wgt_fin_c) begin
            if (last_pass_c) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= NEXT_PASS;
            end
          end
        end

        NEXT_PASS: begin
          act_base            <= act_base + ACT_SRAM_ADDR'(act_total);
          wgt_base            <= wgt_base + WEIGHT_SRAM_ADDR'(wgt_total);
          pass_cnt            <= pass_cnt + 2'd1;
          act_cnt             <= '0;
          wgt_cnt             <= '0;
          act_row_mem_addr    <= '0;
          act_row_mem_data    <= '0;
          weight_row_mem_addr <= '0;
          weight_row_mem_data <= '0;
          state               <= READ;
        end

        DONE: begin
          act_row_mem_addr    <= '0;
          act_row_mem_data    <= '0;
          weight_row_mem_addr <= '0;
          weight_row_mem_data <= '0;
          state               <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
